// File: rtl/conv_output_stage.sv
// Buffers convolution results, shifts/saturates, applies mute-ramp gain; audio_out updates 2 cycles after audio_trigger.
// No backpressure: pushes on a full FIFO are dropped and pops on empty reuse the last sample, both counted.
module conv_output_stage #(
    parameter int FIFO_DEPTH = 4,
    parameter int RAMP_STEP  = 1
) (
    input  logic               audio_clk,
    input  logic               rst_in,
    input  logic signed [47:0] conv_result_in,
    input  logic               conv_valid_in,
    input  logic               audio_trigger,
    input  logic [4:0]         shift_amount,
    input  logic               enable_in,
    output logic signed [15:0] audio_out,
    output logic               audio_valid_out,
    output logic               sat_out,
    output logic [7:0]         underflow_count,
    output logic [7:0]         overflow_count,
    output logic               muted_out
);
    localparam int              PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [8:0]      GAIN_MAX  = 9'd256;
    localparam logic [9:0]      STEP      = 10'(RAMP_STEP);

    typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

    logic signed [47:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W:0]     count;
    logic signed [47:0] held_dat;

    logic               fifo_empty;
    logic               fifo_full;
    logic               pop_ok;
    logic               push_ok;
    logic signed [47:0] pop_dat;
    logic signed [47:0] shifted;
    logic               clip_hi;
    logic               clip_lo;

    logic               s1_vld;
    logic signed [15:0] s1_dat;
    logic               s1_sat;
    logic [8:0]         s1_gain;
    logic signed [24:0] prod;

    state_t             state;
    logic [8:0]         gain;
    logic [9:0]         gain_sum;
    logic [8:0]         up_gain;
    logic [8:0]         dn_gain;
    state_t             up_state;
    state_t             dn_state;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_CNT);
    assign pop_ok     = audio_trigger && !fifo_empty;
    // A pop on a full FIFO frees a slot in the same cycle, so the push is accepted.
    assign push_ok    = conv_valid_in && (!fifo_full || pop_ok);
    assign pop_dat    = pop_ok ? mem[rd_ptr] : held_dat;

    assign shifted = pop_dat >>> shift_amount;
    assign clip_hi = (shifted > 48'sd32767);
    assign clip_lo = (shifted < -48'sd32768);

    always_ff @(posedge audio_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= conv_result_in;
        end
    end

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            held_dat        <= '0;
            underflow_count <= '0;
            overflow_count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                held_dat <= mem[rd_ptr];
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
            if (audio_trigger && fifo_empty && underflow_count != 8'hFF) begin
                underflow_count <= underflow_count + 8'd1;
            end
            if (conv_valid_in && fifo_full && !audio_trigger && overflow_count != 8'hFF) begin
                overflow_count <= overflow_count + 8'd1;
            end
        end
    end

    // Stage 1: shift and saturate; the gain of the trigger cycle travels with the sample.
    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            s1_vld  <= 1'b0;
            s1_dat  <= '0;
            s1_sat  <= 1'b0;
            s1_gain <= '0;
        end else begin
            s1_vld <= audio_trigger;
            if (audio_trigger) begin
                s1_gain <= gain;
                s1_sat  <= clip_hi || clip_lo;
                if (clip_hi) begin
                    s1_dat <= 16'sh7FFF;
                end else if (clip_lo) begin
                    s1_dat <= -16'sh8000;
                end else begin
                    s1_dat <= 16'(shifted);
                end
            end
        end
    end

    // |s1_dat * gain| <= 2^23, so 25 signed bits hold the product exactly.
    assign prod = 25'(s1_dat) * $signed({16'b0, s1_gain});

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            audio_out       <= '0;
            audio_valid_out <= 1'b0;
            sat_out         <= 1'b0;
        end else begin
            audio_valid_out <= s1_vld;
            if (s1_vld) begin
                audio_out <= 16'(prod >>> 8);
                sat_out   <= s1_sat;
            end
        end
    end

    assign gain_sum = {1'b0, gain} + STEP;
    assign up_gain  = (gain_sum >= {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_sum[8:0];
    assign dn_gain  = ({1'b0, gain} <= STEP) ? 9'd0 : 9'({1'b0, gain} - STEP);
    assign up_state = (up_gain == GAIN_MAX) ? ACTIVE : RAMP_UP;
    assign dn_state = (dn_gain == 9'd0) ? MUTED : RAMP_DOWN;

    always_ff @(posedge audio_clk or negedge rst_in) begin
        if (!rst_in) begin
            state     <= MUTED;
            gain      <= '0;
            muted_out <= 1'b1;
        end else if (audio_trigger) begin
            unique case (state)
                MUTED: begin
                    if (enable_in) begin
                        state     <= up_state;
                        gain      <= up_gain;
                        muted_out <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!enable_in) begin
                        state     <= dn_state;
                        gain      <= dn_gain;
                        muted_out <= (dn_state == MUTED);
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (enable_in) begin
                        state     <= up_state;
                        gain      <= up_gain;
                        muted_out <= 1'b0;
                    end else begin
                        state     <= dn_state;
                        gain      <= dn_gain;
                        muted_out <= (dn_state == MUTED);
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/conv_output_stage.md
CONV_OUTPUT_STAGE -- requirements
Module: conv_output_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered convolution results (power of 2, 2..16).
REQ-002 SHALL have parameter RAMP_STEP, default 1, gain increment/decrement applied per audio_trigger during a mute ramp.
REQ-003 SHALL have port audio_clk  input  1  sole clock, all logic on its rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port conv_result_in  input  48  signed convolution result.
REQ-006 SHALL have port conv_valid_in  input  1  one-cycle strobe qualifying conv_result_in (push).
REQ-007 SHALL have port audio_trigger  input  1  one-cycle 24 kHz sample tick (pop).
REQ-008 SHALL have port shift_amount  input  5  arithmetic right shift applied before saturation.
REQ-009 SHALL have port enable_in  input  1  level; 1 = unmute, 0 = mute.
REQ-010 SHALL have port audio_out  output  16  signed sample for pdm, held between updates.
REQ-011 SHALL have port audio_valid_out  output  1  one-cycle strobe when audio_out updates.
REQ-012 SHALL have port sat_out  output  1  1 if the current audio_out sample was clipped.
REQ-013 SHALL have port underflow_count  output  8  saturating count of pops on empty FIFO.
REQ-014 SHALL have port overflow_count  output  8  saturating count of pushes dropped on full FIFO.
REQ-015 SHALL have port muted_out  output  1  1 when FSM is in MUTED.

Function
REQ-016 FIFO SHALL store conv_result_in on conv_valid_in when not full; pointers wrap modulo FIFO_DEPTH.
REQ-017 Push on full with no same-cycle pop SHALL drop the new sample, keep contents, increment overflow_count (saturate at 255).
REQ-018 Push and pop in same cycle on full SHALL both succeed; no overflow counted.
REQ-019 Pop on empty (including same-cycle push onto empty) SHALL count an underflow (saturate at 255), store the pushed sample, and reuse the previous pre-gain sample.
REQ-020 Stage 1 (cycle after audio_trigger) SHALL compute popped value >>> shift_amount (sampled at the trigger), saturate to [-32768, 32767], set sat flag if clipped.
REQ-021 Stage 2 SHALL compute (stage1 * gain) >>> 8 with gain in 0..256, 25-bit signed intermediate, 256 = unity, result exact in 16 bits.
REQ-022 audio_out, sat_out SHALL update and audio_valid_out pulse exactly 2 cycles after audio_trigger; otherwise audio_out holds.
REQ-023 Gain used for a sample SHALL be the gain value in the audio_trigger cycle; gain then steps for the next trigger.
REQ-024 FSM states: MUTED (gain 0), RAMP_UP, ACTIVE (gain 256), RAMP_DOWN.
REQ-025 MUTED -> RAMP_UP when enable_in=1 at an audio_trigger.
REQ-026 RAMP_UP: gain += RAMP_STEP per trigger, clamped to 256; -> ACTIVE on reaching 256; -> RAMP_DOWN if enable_in=0 at a trigger.
REQ-027 ACTIVE -> RAMP_DOWN when enable_in=0 at a trigger.
REQ-028 RAMP_DOWN: gain -= RAMP_STEP per trigger, clamped to 0; -> MUTED on reaching 0; -> RAMP_UP if enable_in=1 at a trigger.
REQ-029 FSM and gain SHALL change only on audio_trigger cycles.
REQ-030 Triggers arriving 1 cycle apart SHALL each produce a valid output, in order (fully pipelined).

Reset
REQ-031 rst_in=0 SHALL immediately clear FIFO pointers, counters, gain=0, FSM=MUTED, held sample=0, pipeline valids=0.
REQ-032 During reset: audio_out=0, audio_valid_out=0, sat_out=0, underflow_count=0, overflow_count=0, muted_out=1.
REQ-033 Reset asserted mid-ramp or mid-pipeline SHALL discard in-flight samples; first post-reset audio_valid_out requires a new audio_trigger.

Verification
REQ-034 enable_in=1, wait 256 triggers (RAMP_STEP=1), push 48'sd1000, shift 0, trigger -> audio_out=1000, sat_out=0, valid 2 cycles after trigger.
REQ-035 ACTIVE, push 48'sh0000_0010_0000 (2^20), shift 4 -> 32767 sat_out=1; push -(2^20), shift 4 -> -32768 sat_out=1; shift 5 -> 32768 clips, shift 6 -> 16384 sat_out=0.
REQ-036 From MUTED, enable_in=1, push 8 per trigger of 48'sd256 (ACTIVE path, shift 0) -> outputs 0,1,2,...; enable_in=0 after 10 triggers -> gain ramps down from 10, muted_out=1 at 0.
REQ-037 Push 6 samples without pop (depth 4) -> overflow_count=2, next 4 pops return first 4 in order, 5th pop -> underflow_count=1, output repeats 4th sample.
REQ-038 Full FIFO with simultaneous push+pop -> overflow_count unchanged, ordering preserved; empty with simultaneous push+pop -> underflow_count+1, pushed value emerges on next pop.
REQ-039 Assert rst_in=0 during RAMP_UP gain=100 with sample in pipeline -> all outputs reset values same cycle, no audio_valid_out until next trigger after release.
